// File: rtl/exec_flow_unit.sv
// Execute stage and next-PC logic of the single-cycle 8-bit core: operand-2 mux,
// ALU with zero flag, write-back mux, and the 32-bit PC register.
module exec_flow_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUSYWAIT,
    input  logic [7:0]  REGOUT1,
    input  logic [7:0]  REGOUT2,
    input  logic [7:0]  IMMEDIATE,
    input  logic [7:0]  OFFSET,
    input  logic [2:0]  ALUOP,
    input  logic        SIGN_SELECT,
    input  logic        IMM_SELECT,
    input  logic        JUMP,
    input  logic        BRANCH,
    input  logic        BNE,
    input  logic [7:0]  READDATA,
    input  logic        WB_SELECT,
    output logic [31:0] PC,
    output logic [7:0]  ALURESULT,
    output logic        ZERO,
    output logic [7:0]  WRITEDATA_REG
);

    typedef enum logic [2:0] {
        OP_FWD  = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MULT = 3'b100,
        OP_SHL  = 3'b101,
        OP_SRA  = 3'b110,
        OP_ROR  = 3'b111
    } alu_op_e;

    logic [7:0]  neg_op2;
    logic [7:0]  op2a;
    logic [7:0]  operand2;
    logic [3:0]  shamt;
    logic [7:0]  lsh_res;
    logic [7:0]  sra_res;
    logic [7:0]  ror_res;
    logic [7:0]  mul_res;
    logic [31:0] pc4;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        take;

    // Operand 2: register, its two's complement (SUB/BEQ/BNE), or the immediate
    assign neg_op2  = (~REGOUT2) + 8'd1;
    assign op2a     = SIGN_SELECT ? neg_op2 : REGOUT2;
    assign operand2 = IMM_SELECT ? IMMEDIATE : op2a;

    assign shamt = operand2[3:0];

    // Low byte of a product is identical for signed and unsigned operands
    assign mul_res = REGOUT1 * operand2;

    // Shift amounts of 8..15 naturally empty the byte (zero or sign fill)
    always_comb begin
        lsh_res = 8'h00;
        if (operand2[7])
            lsh_res = REGOUT1 >> shamt;
        else
            lsh_res = REGOUT1 << shamt;
    end

    assign sra_res = $signed(REGOUT1) >>> shamt;

    always_comb begin
        logic [2:0] idx;
        ror_res = 8'h00;
        idx     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx        = 3'(i) + operand2[2:0];
            ror_res[i] = REGOUT1[idx];
        end
    end

    always_comb begin
        ALURESULT = 8'h00;
        case (alu_op_e'(ALUOP))
            OP_FWD:  ALURESULT = operand2;
            OP_ADD:  ALURESULT = REGOUT1 + operand2;
            OP_AND:  ALURESULT = REGOUT1 & operand2;
            OP_OR:   ALURESULT = REGOUT1 | operand2;
            OP_MULT: ALURESULT = mul_res;
            OP_SHL:  ALURESULT = lsh_res;
            OP_SRA:  ALURESULT = sra_res;
            OP_ROR:  ALURESULT = ror_res;
            default: ALURESULT = 8'h00;
        endcase
    end

    assign ZERO          = (ALURESULT == 8'h00);
    assign WRITEDATA_REG = WB_SELECT ? READDATA : ALURESULT;

    // OFFSET counts instructions, so it is scaled to bytes before the add
    assign pc4     = PC + 32'd4;
    assign target  = pc4 + {{22{OFFSET[7]}}, OFFSET, 2'b00};
    assign take    = JUMP | (BRANCH & (ZERO ^ BNE));
    assign next_pc = take ? target : pc4;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            PC <= 32'h0;
        else if (!BUSYWAIT)
            PC <= next_pc;
    end

endmodule

// File: tb/tb_exec_flow_unit.sv
// Directed and randomized checks of exec_flow_unit against an arithmetic reference model.
module tb_exec_flow_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BUSYWAIT;
    logic [7:0]  REGOUT1, REGOUT2, IMMEDIATE, OFFSET, READDATA;
    logic [2:0]  ALUOP;
    logic        SIGN_SELECT, IMM_SELECT, JUMP, BRANCH, BNE, WB_SELECT;
    logic [31:0] PC;
    logic [7:0]  ALURESULT, WRITEDATA_REG;
    logic        ZERO;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] pc_m;

    exec_flow_unit dut (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT),
        .REGOUT1(REGOUT1), .REGOUT2(REGOUT2), .IMMEDIATE(IMMEDIATE), .OFFSET(OFFSET),
        .ALUOP(ALUOP), .SIGN_SELECT(SIGN_SELECT), .IMM_SELECT(IMM_SELECT),
        .JUMP(JUMP), .BRANCH(BRANCH), .BNE(BNE),
        .READDATA(READDATA), .WB_SELECT(WB_SELECT),
        .PC(PC), .ALURESULT(ALURESULT), .ZERO(ZERO), .WRITEDATA_REG(WRITEDATA_REG)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout PC=%h", PC);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference ALU in plain integer arithmetic
    function automatic int m_result(input int r1, input int r2, input int imm, input int op,
                                    input bit ss, input bit is);
        int d2, amt, p, s1, q, r;
        d2 = is ? imm : (ss ? (256 - r2) % 256 : r2);
        amt = d2 % 16;
        r = 0;
        case (op)
            0: r = d2;
            1: r = (r1 + d2) % 256;
            2: r = r1 & d2;
            3: r = r1 | d2;
            4: r = (to_signed8(r1) * to_signed8(d2)) & 255;
            5: begin
                p = 1 << amt;
                if (amt >= 8)       r = 0;
                else if (d2 >= 128) r = r1 / p;
                else                r = (r1 * p) % 256;
            end
            6: begin
                s1 = to_signed8(r1);
                if (amt >= 8) r = (s1 < 0) ? 255 : 0;
                else begin
                    p = 1 << amt;
                    q = s1 / p;
                    if (s1 < 0 && (s1 % p) != 0) q = q - 1;
                    r = q & 255;
                end
            end
            default: begin
                amt = d2 % 8;
                r = ((r1 >> amt) | (r1 << (8 - amt))) & 255;
            end
        endcase
        return r;
    endfunction

    function automatic int cur_result();
        return m_result(int'(REGOUT1), int'(REGOUT2), int'(IMMEDIATE), int'(ALUOP),
                        SIGN_SELECT, IMM_SELECT);
    endfunction

    task automatic check_comb(input string tag);
        int r;
        #1;
        r = cur_result();
        check({tag, "_alu"}, 32'(ALURESULT), 32'(r));
        check({tag, "_zero"}, 32'(ZERO), 32'(r == 0));
        check({tag, "_wb"}, 32'(WRITEDATA_REG), WB_SELECT ? 32'(READDATA) : 32'(r));
    endtask

    // One clock edge; expected PC derived from the model before the edge
    task automatic step(input string tag);
        logic [31:0] nxt;
        bit z, take;
        z    = (cur_result() == 0);
        take = JUMP || (BRANCH && (z != BNE));
        if (!RESET)        nxt = 32'h0;
        else if (BUSYWAIT) nxt = pc_m;
        else if (take)     nxt = pc_m + 32'd4 + 32'(to_signed8(int'(OFFSET)) * 4);
        else               nxt = pc_m + 32'd4;
        @(posedge CLK);
        #1;
        pc_m = nxt;
        check(tag, PC, pc_m);
    endtask

    task automatic alu(input string tag, input logic [2:0] op, input logic [7:0] r1,
                       input logic [7:0] r2, input logic [7:0] imm, input bit ss, input bit is,
                       input logic [7:0] exp);
        ALUOP = op; REGOUT1 = r1; REGOUT2 = r2; IMMEDIATE = imm;
        SIGN_SELECT = ss; IMM_SELECT = is; WB_SELECT = 1'b0;
        #1;
        check(tag, 32'(ALURESULT), 32'(exp));
        check({tag, "_z"}, 32'(ZERO), 32'(exp == 8'h00));
    endtask

    task automatic goto8();
        JUMP = 0; BRANCH = 0; BNE = 0; BUSYWAIT = 0;
        RESET = 0;
        #1;
        pc_m = 32'h0;
        RESET = 1;
        step("goto8_a");
        step("goto8_b");
    endtask

    task automatic branch(input string tag, input bit j, input bit b, input bit bn,
                          input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] off,
                          input logic [31:0] exp_pc);
        goto8();
        ALUOP = 3'b001; SIGN_SELECT = 1; IMM_SELECT = 0;
        REGOUT1 = r1; REGOUT2 = r2; OFFSET = off;
        JUMP = j; BRANCH = b; BNE = bn;
        step({tag, "_model"});
        check(tag, PC, exp_pc);
        JUMP = 0; BRANCH = 0; BNE = 0;
    endtask

    initial begin
        RESET = 1; BUSYWAIT = 1;
        REGOUT1 = 0; REGOUT2 = 0; IMMEDIATE = 0; OFFSET = 0; READDATA = 0;
        ALUOP = 0; SIGN_SELECT = 0; IMM_SELECT = 0;
        JUMP = 0; BRANCH = 0; BNE = 0; WB_SELECT = 0;
        pc_m = 32'h0;

        // Asynchronous reset, held, then first edge after release
        @(posedge CLK);
        #2;
        RESET = 0;
        #1;
        check("rst_async", PC, 32'h0);
        @(posedge CLK);
        #1;
        check("rst_hold", PC, 32'h0);
        @(negedge CLK);
        RESET = 1; BUSYWAIT = 0;
        step("rst_first_model");
        check("rst_first", PC, 32'd4);

        // Combinational ALU checks with PC parked
        BUSYWAIT = 1;
        alu("add",  3'b001, 8'h0F, 8'h05, 8'h00, 0, 0, 8'h14);
        alu("sub",  3'b001, 8'h0F, 8'h05, 8'h00, 1, 0, 8'h0A);
        alu("and",  3'b010, 8'h0F, 8'h05, 8'h00, 0, 0, 8'h05);
        alu("or",   3'b011, 8'h0F, 8'h05, 8'h00, 0, 0, 8'h0F);
        alu("mult", 3'b100, 8'h0F, 8'h05, 8'h00, 0, 0, 8'h4B);
        alu("fwd",  3'b000, 8'h0F, 8'h05, 8'hAB, 0, 1, 8'hAB);
        alu("sll",  3'b101, 8'h81, 8'h00, 8'h02, 0, 1, 8'h04);
        alu("srl",  3'b101, 8'h81, 8'h00, 8'h82, 0, 1, 8'h20);
        alu("sra",  3'b110, 8'h81, 8'h00, 8'h02, 0, 1, 8'hE0);
        alu("ror",  3'b111, 8'h81, 8'h00, 8'h01, 0, 1, 8'hC0);
        alu("sra9", 3'b110, 8'h81, 8'h00, 8'h09, 0, 1, 8'hFF);
        alu("sll9", 3'b101, 8'h81, 8'h00, 8'h09, 0, 1, 8'h00);
        alu("ror9", 3'b111, 8'h81, 8'h00, 8'h09, 0, 1, 8'hC0);
        alu("mneg", 3'b100, 8'hFD, 8'h07, 8'h00, 0, 0, 8'hEB);
        alu("sub0", 3'b001, 8'h33, 8'h33, 8'h00, 1, 0, 8'h00);

        // Write-back mux
        ALUOP = 3'b001; REGOUT1 = 8'h0F; REGOUT2 = 8'h05; SIGN_SELECT = 0; IMM_SELECT = 0;
        READDATA = 8'h5A; WB_SELECT = 1;
        #1;
        check("wb_mem", 32'(WRITEDATA_REG), 32'h5A);
        WB_SELECT = 0;
        #1;
        check("wb_alu", 32'(WRITEDATA_REG), 32'h14);
        step("hold_during_alu");

        // Flow control from PC=8
        branch("beq_taken",  0, 1, 0, 8'h33, 8'h33, 8'hFE, 32'd4);
        branch("bne_fall",   0, 1, 1, 8'h33, 8'h33, 8'hFE, 32'd12);
        branch("beq_fall",   0, 1, 0, 8'h33, 8'h21, 8'hFE, 32'd12);
        branch("bne_taken",  0, 1, 1, 8'h33, 8'h21, 8'hFE, 32'd4);
        branch("jump",       1, 0, 0, 8'h33, 8'h21, 8'h03, 32'd24);
        branch("bne_nobr",   0, 0, 1, 8'h33, 8'h21, 8'hFE, 32'd12);
        branch("jump_wrap",  1, 0, 0, 8'h33, 8'h33, 8'h80, 32'hFFFF_FE0C);

        // Stall, release, and reset during stall
        goto8();
        BUSYWAIT = 1;
        for (int i = 0; i < 3; i++) step("stall");
        check("stall_const", PC, 32'd8);
        BUSYWAIT = 0;
        step("stall_release");
        check("stall_release_const", PC, 32'd12);
        BUSYWAIT = 1;
        RESET = 0;
        #1;
        check("rst_mid_stall", PC, 32'h0);
        pc_m = 32'h0;
        RESET = 1;
        BUSYWAIT = 0;

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            REGOUT1     = 8'($urandom);
            REGOUT2     = ($urandom % 4 == 0) ? REGOUT1 : 8'($urandom);
            IMMEDIATE   = 8'($urandom);
            OFFSET      = 8'($urandom);
            READDATA    = 8'($urandom);
            ALUOP       = 3'($urandom);
            SIGN_SELECT = 1'($urandom);
            IMM_SELECT  = ($urandom % 3 == 0);
            WB_SELECT   = 1'($urandom);
            BUSYWAIT    = ($urandom % 4 == 0);
            JUMP        = ($urandom % 8 == 0);
            BRANCH      = ($urandom % 3 == 0);
            BNE         = 1'($urandom);
            check_comb("rnd");
            if ($urandom % 20 == 0) begin
                RESET = 0;
                #1;
                check("rnd_rst", PC, 32'h0);
                pc_m = 32'h0;
                RESET = 1;
            end
            step("rnd_pc");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exec_flow_unit.md
# exec_flow_unit

Execute-and-next-PC block of the single-cycle 8-bit processor. Combinationally selects the second ALU operand, computes the 8-bit ALU result and zero flag, and selects the register write-back data. It also owns the 32-bit program counter and advances it each clock to PC+4, or to a jump/branch target, unless memory stalls the core.

## Interface
- No parameters; datapath 8 bits, PC 32 bits, fixed.
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- BUSYWAIT  in  1  memory stall; high holds PC.
- REGOUT1  in  8  register operand 1 (ALU DATA1, signed).
- REGOUT2  in  8  register operand 2 (signed).
- IMMEDIATE  in  8  instruction immediate field.
- OFFSET  in  8  signed branch/jump offset in instructions.
- ALUOP  in  3  ALU operation select.
- SIGN_SELECT  in  1  1: use two's complement of REGOUT2.
- IMM_SELECT  in  1  1: use IMMEDIATE as operand 2.
- JUMP, BRANCH, BNE  in  1 each  flow-control strobes.
- READDATA  in  8  data-memory read data.
- WB_SELECT  in  1  1: write back READDATA, 0: ALURESULT.
- PC  out  32  program counter (registered).
- ALURESULT  out  8  ALU result; also the data-memory address.
- ZERO  out  1  ALURESULT == 0.
- WRITEDATA_REG  out  8  register-file write data.

## Operation
- NEG = (~REGOUT2)+1, mod 256. OP2A = SIGN_SELECT ? NEG : REGOUT2. OPERAND2 = IMM_SELECT ? IMMEDIATE : OP2A.
- ALU, with D1=REGOUT1 and D2=OPERAND2:
  - 000 FORWARD: D2.
  - 001 ADD: D1+D2 mod 256. SUB, BEQ and BNE use this op with SIGN_SELECT=1.
  - 010 AND: D1&D2.
  - 011 OR: D1|D2.
  - 100 MULT: low 8 bits of the signed product D1*D2.
  - 101 logical shift: amount = D2[3:0]. D2[7]=0 shifts left, D2[7]=1 shifts right. Zero fill. Amount ≥8 gives 0x00.
  - 110 SRA: right shift by D2[3:0] with sign fill. Amount ≥8 gives 0x00 or 0xFF according to D1[7].
  - 111 ROR: rotate right by D2[2:0]; higher bits are ignored.
- ZERO = (ALURESULT == 8'h00), for every ALUOP.
- WRITEDATA_REG = WB_SELECT ? READDATA : ALURESULT.
- PC4 = PC + 4. TARGET = PC4 + (sign-extended OFFSET << 2), mod 2^32.
- TAKE = JUMP | (BRANCH & (ZERO ^ BNE)).
  - BEQ (BRANCH=1, BNE=0) is taken when ZERO=1.
  - BNE (BRANCH=1, BNE=1) is taken when ZERO=0.
  - JUMP takes priority and ignores ZERO.
- NEXT_PC = TAKE ? TARGET : PC4.
- BNE with BRANCH=0 has no effect.

## Timing
- Everything except PC is purely combinational, with no internal state.
- RESET low clears PC to 32'h0 immediately, independent of CLK. PC stays 0 while RESET is low.
- After RESET rises, the first rising CLK edge loads NEXT_PC (normally 4).
- On a rising CLK edge with RESET high:
  - BUSYWAIT=0: PC <= NEXT_PC.
  - BUSYWAIT=1: PC holds.
- There is no multi-cycle stall accounting. The edge following BUSYWAIT falling advances normally.
- TAKE is evaluated from the ZERO value settled before the edge; there are no delay slots.
- If RESET is asserted mid-stall or mid-branch, reset wins and PC=0.
- Offset wrap: OFFSET=0x80 gives TARGET = PC4 − 512. PC wraps modulo 2^32.

## Test plan
- Reset: drive RESET low asynchronously → PC=0 with no clock edge. Release RESET, then one CLK edge → PC=4.
- ALU sweep, D1=0x0F, register operand 2 = 0x05:
  - ADD → 0x14.
  - SUB (SIGN_SELECT=1) → 0x0A.
  - AND → 0x05.
  - OR → 0x0F.
  - MULT → 0x4B.
  - FORWARD with IMMEDIATE=0xAB, IMM_SELECT=1 → 0xAB.
- Shifts with IMM_SELECT=1:
  - D1=0x81, imm 0x02, op 101 → 0x04.
  - D1=0x81, imm 0x82, op 101 → 0x20.
  - D1=0x81, imm 0x02, op 110 → 0xE0.
  - D1=0x81, imm 0x01, op 111 → 0xC0.
  - D1=0x81, imm 0x09, op 110 → 0xFF.
- Branches, PC=8, OFFSET=0xFE, equal operands (ZERO=1):
  - BEQ → PC becomes 4.
  - BNE → PC becomes 12.
  - With unequal operands, BEQ → 12 and BNE → 4.
  - JUMP with OFFSET=0x03 → PC becomes 24.
- Stall: hold BUSYWAIT=1 for 3 edges → PC unchanged. Drop BUSYWAIT → next edge advances PC by 4.
- Write-back: READDATA=0x5A, WB_SELECT=1 → WRITEDATA_REG=0x5A. WB_SELECT=0 → WRITEDATA_REG equals ALURESULT.
